// File: rtl/adder_pkg.sv
// Shared constants and mode encoding for the
// pipelined adder-subtractor datapath.
package adder_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int STAGES_DEF = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/adder_seg.sv
// Combinational ripple segment: one slice of
// the pipelined adder, plus carry into its MSB.
module adder_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b}
            + {{SEG_W{1'b0}}, ci};
  end

  // sum bit = a ^ b ^ carry-in, so the carry is recovered
  assign c_msb_in = a[SEG_W-1] ^ b[SEG_W-1]
                  ^ s[SEG_W-1];

endmodule

// File: rtl/pipe_adder_n.sv
// Pipelined N-bit adder-subtractor, one segment
// per stage, carry rippling between stage regs.
module pipe_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG_W = WIDTH / STAGES;

  mode_e mode;
  logic  en;

  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];
  logic [WIDTH-1:0] rs [STAGES];
  logic             rc [STAGES];
  logic             rv [STAGES];
  logic             rm;

  logic [WIDTH-1:0] xa [STAGES];
  logic [WIDTH-1:0] xb [STAGES];
  logic [WIDTH-1:0] xs [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic             xci [STAGES];
  logic             xv [STAGES];

  logic [SEG_W-1:0] seg_s  [STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];

  assign mode     = mode_e'(sub);
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  always_comb begin
    xa[0]  = a;
    xb[0]  = (mode == MODE_SUB) ? ~b : b;
    xci[0] = (mode == MODE_SUB) ? 1'b1 : cin;
    xs[0]  = '0;
    xv[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      xa[k]  = ra[k-1];
      xb[k]  = rb[k-1];
      xci[k] = rc[k-1];
      xs[k]  = rs[k-1];
      xv[k]  = rv[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ns[k] = xs[k];
      ns[k][k*SEG_W +: SEG_W] = seg_s[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a        (xa[k][k*SEG_W +: SEG_W]),
      .b        (xb[k][k*SEG_W +: SEG_W]),
      .ci       (xci[k]),
      .s        (seg_s[k]),
      .co       (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );
  end

  // data regs load only with a valid beat so
  // bubbles leave the last result on the outputs
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        rv[k] <= 1'b0;
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
        rc[k] <= 1'b0;
      end
      rm <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        rv[k] <= xv[k];
        if (xv[k]) begin
          ra[k] <= xa[k];
          rb[k] <= xb[k];
          rs[k] <= ns[k];
          rc[k] <= seg_co[k];
        end
      end
      if (xv[STAGES-1]) begin
        rm <= seg_cm[STAGES-1];
      end
    end
  end

  assign out_valid = rv[STAGES-1];
  assign sum       = rs[STAGES-1];
  assign cout      = rc[STAGES-1];
  assign ovf       = rm ^ rc[STAGES-1];

endmodule
